// File: rtl/mdu_pkg.sv
// Shared constants and types for the multiply/divide unit.
// Funct codes, FSM encoding, iteration count and latched-operation record.
package mdu_pkg;

  localparam int ITER = 32;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mdu_state_t;

  // Everything FIN needs to finish the operation once the EX operands are gone.
  typedef struct packed {
    logic        is_div;
    logic        a_neg;
    logic        b_neg;
    logic        div0;
    logic [31:0] raw_a;
  } mdu_op_t;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative datapath: 64-bit accumulator, one shift-add / restoring shift-subtract step per cycle.
// Latency: one step per cycle while step=1; load takes one edge.
// No backpressure: the controlling FSM decides when to load and step.
module mdu_iter (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] init_lo,
  input  logic [31:0] operand,
  output logic [63:0] acc
);

  logic [63:0] acc_q;
  logic [63:0] acc_d;
  logic [31:0] opnd_q;
  logic [32:0] add_sum;
  logic        ge;
  logic [31:0] sub;

  always_comb begin
    add_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    // Shifted partial remainder is acc_q[63:31]; a successful subtract always fits 32 bits.
    ge      = acc_q[63:31] >= {1'b0, opnd_q};
    sub     = acc_q[62:31] - opnd_q;
    if (is_div) begin
      acc_d = ge ? {sub, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
    end else begin
      acc_d = {add_sum, acc_q[31:1]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else if (load) begin
      acc_q  <= {32'd0, init_lo};
      opnd_q <= operand;
    end else if (step) begin
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage HI/LO unit: MULT/MULTU/DIV/DIVU plus MFHI/MFLO/MTHI/MTLO.
// Latency: 34 cycles start to retire (1 start + 32 RUN + FIN); moves are single-cycle.
// Backpressure: Stall freezes the front of the pipeline for 33 cycles per mul/div.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        RType_EX,
  input  logic [5:0]  Funct_EX,
  input  logic [31:0] RD1_EX,
  input  logic [31:0] RD2_EX,
  output logic        Stall,
  output logic [31:0] HiLo_Out,
  output logic        HiLo_Sel,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_t  state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  mdu_op_t     op_q, op_d;

  logic        is_mfhi, is_mflo, is_mthi, is_mtlo, is_muldiv;
  logic        sgn_op, start, stall_raw;
  logic [31:0] mag_a, mag_b;
  logic [63:0] acc, prod;
  logic [31:0] quot, rem, res_hi, res_lo;

  always_comb begin
    is_mfhi   = RType_EX && (Funct_EX == F_MFHI);
    is_mflo   = RType_EX && (Funct_EX == F_MFLO);
    is_mthi   = RType_EX && (Funct_EX == F_MTHI);
    is_mtlo   = RType_EX && (Funct_EX == F_MTLO);
    is_muldiv = RType_EX && (Funct_EX inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    // bit0 clear = signed form, bit1 set = divide
    sgn_op    = !Funct_EX[0];
    mag_a     = mag32(RD1_EX, sgn_op);
    mag_b     = mag32(RD2_EX, sgn_op);
    op_d.is_div = Funct_EX[1];
    op_d.a_neg  = sgn_op && RD1_EX[31];
    op_d.b_neg  = sgn_op && RD2_EX[31];
    op_d.div0   = Funct_EX[1] && (RD2_EX == 32'd0);
    op_d.raw_a  = RD1_EX;
  end

  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_muldiv) begin
          stall_raw = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        stall_raw = 1'b1;
        if (cnt_q == 6'(ITER - 1)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start = (state_q == IDLE) && is_muldiv;
  assign Stall = stall_raw && !Rst;

  mdu_iter u_iter (
    .Clk     (Clk),
    .Rst     (Rst),
    .load    (start),
    .step    (state_q == RUN),
    .is_div  (op_q.is_div),
    .init_lo (Funct_EX[1] ? mag_a : mag_b),
    .operand (Funct_EX[1] ? mag_b : mag_a),
    .acc     (acc)
  );

  always_comb begin
    prod = (op_q.a_neg ^ op_q.b_neg) ? (64'd0 - acc) : acc;
    quot = (op_q.a_neg ^ op_q.b_neg) ? (32'd0 - acc[31:0]) : acc[31:0];
    rem  = op_q.a_neg ? (32'd0 - acc[63:32]) : acc[63:32];
    if (op_q.div0) begin
      res_hi = op_q.raw_a;
      res_lo = 32'hFFFF_FFFF;
    end else if (op_q.is_div) begin
      res_hi = rem;
      res_lo = quot;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q <= '0;
        op_q  <= op_d;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + 6'd1;
      end
      if (state_q == FIN) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state_q == IDLE) begin
        if (is_mthi) hi_q <= RD1_EX;
        if (is_mtlo) lo_q <= RD1_EX;
      end
    end
  end

  always_comb begin
    HiLo_Out = 32'd0;
    if (!Rst) begin
      if (is_mfhi)      HiLo_Out = hi_q;
      else if (is_mflo) HiLo_Out = lo_q;
    end
  end

  assign HiLo_Sel = !Rst && (is_mfhi || is_mflo);
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: mul/div results, stall length,
// moves, divide-by-zero, signed corners and reset abandoning an operation.
module tb_mul_div_unit;

  localparam logic [5:0] T_MFHI  = 6'h10;
  localparam logic [5:0] T_MTHI  = 6'h11;
  localparam logic [5:0] T_MFLO  = 6'h12;
  localparam logic [5:0] T_MTLO  = 6'h13;
  localparam logic [5:0] T_MULT  = 6'h18;
  localparam logic [5:0] T_MULTU = 6'h19;
  localparam logic [5:0] T_DIV   = 6'h1A;
  localparam logic [5:0] T_DIVU  = 6'h1B;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        RType_EX;
  logic [5:0]  Funct_EX;
  logic [31:0] RD1_EX, RD2_EX;
  logic        Stall, HiLo_Sel;
  logic [31:0] HiLo_Out, HI, LO;

  int n_cmp = 0;
  int n_bad = 0;
  int s1, s2;

  mul_div_unit dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .RType_EX (RType_EX),
    .Funct_EX (Funct_EX),
    .RD1_EX   (RD1_EX),
    .RD2_EX   (RD2_EX),
    .Stall    (Stall),
    .HiLo_Out (HiLo_Out),
    .HiLo_Sel (HiLo_Sel),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 Clk = ~Clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic rt, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    RType_EX = rt;
    Funct_EX = f;
    RD1_EX   = a;
    RD2_EX   = b;
  endtask

  // Holds the op in EX while stalled, then clocks the FIN edge. chg_at>0 swaps
  // the EX fields after that many stall cycles to show the latched operands win.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int chg_at, output int n);
    drive(1'b1, f, a, b);
    #1;
    n = 0;
    while (Stall && n < 100) begin
      n++;
      tick();
      if (n == chg_at) begin
        drive(1'b1, T_DIVU, 32'd0, 32'd0);
        #1;
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1;
    drive(1'b1, T_MULT, 32'd3, 32'd5);
    tick();
    tick();
    chk_eq("rst_stall", 64'(Stall), 64'd0);
    chk_eq("rst_hi", 64'(HI), 64'd0);
    chk_eq("rst_lo", 64'(LO), 64'd0);
    drive(1'b1, T_MFHI, 32'd0, 32'd0);
    #1;
    chk_eq("rst_hilo_out", 64'(HiLo_Out), 64'd0);
    Rst = 1'b0;
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    tick();

    // MULTU max x max, with EX fields scrambled mid-RUN
    run_op(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, s1);
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    #1;
    chk_eq("multu_max_stalls", 64'(s1), 64'd33);
    chk_eq("multu_max_hi", 64'(HI), 64'hFFFF_FFFE);
    chk_eq("multu_max_lo", 64'(LO), 64'h0000_0001);
    chk_eq("multu_max_idle", 64'(Stall), 64'd0);

    // DIV -7 / 2, MFHI/MFLO right after
    run_op(T_DIV, 32'hFFFF_FFF9, 32'd2, 0, s1);
    drive(1'b1, T_MFHI, 32'd0, 32'd0);
    #1;
    chk_eq("div_m7_stalls", 64'(s1), 64'd33);
    chk_eq("div_m7_lo", 64'(LO), 64'hFFFF_FFFD);
    chk_eq("div_m7_hi", 64'(HI), 64'hFFFF_FFFF);
    chk_eq("mfhi_out", 64'(HiLo_Out), 64'hFFFF_FFFF);
    chk_eq("mfhi_sel", 64'(HiLo_Sel), 64'd1);
    chk_eq("mfhi_stall", 64'(Stall), 64'd0);
    tick();
    drive(1'b1, T_MFLO, 32'd0, 32'd0);
    #1;
    chk_eq("mflo_out", 64'(HiLo_Out), 64'hFFFF_FFFD);
    tick();

    // divide by zero, both forms
    run_op(T_DIVU, 32'd100, 32'd0, 0, s1);
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    #1;
    chk_eq("divu_z_stalls", 64'(s1), 64'd33);
    chk_eq("divu_z_lo", 64'(LO), 64'hFFFF_FFFF);
    chk_eq("divu_z_hi", 64'(HI), 64'h0000_0064);
    run_op(T_DIV, 32'hFFFF_FF9C, 32'd0, 0, s1);
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    #1;
    chk_eq("div_z_stalls", 64'(s1), 64'd33);
    chk_eq("div_z_lo", 64'(LO), 64'hFFFF_FFFF);
    chk_eq("div_z_hi", 64'(HI), 64'hFFFF_FF9C);

    // moves never stall
    drive(1'b1, T_MTHI, 32'h1234_5678, 32'd0);
    #1;
    chk_eq("mthi_stall", 64'(Stall), 64'd0);
    tick();
    drive(1'b1, T_MTLO, 32'hCAFE_BABE, 32'd0);
    #1;
    chk_eq("mtlo_stall", 64'(Stall), 64'd0);
    tick();
    drive(1'b1, T_MFLO, 32'd0, 32'd0);
    #1;
    chk_eq("mv_stall", 64'(Stall), 64'd0);
    chk_eq("mv_hi", 64'(HI), 64'h1234_5678);
    chk_eq("mv_mflo_out", 64'(HiLo_Out), 64'hCAFE_BABE);
    chk_eq("mv_mflo_sel", 64'(HiLo_Sel), 64'd1);
    drive(1'b1, 6'h20, 32'd1, 32'd2);
    #1;
    chk_eq("nop_sel", 64'(HiLo_Sel), 64'd0);
    chk_eq("nop_out", 64'(HiLo_Out), 64'd0);
    chk_eq("nop_stall", 64'(Stall), 64'd0);
    drive(1'b0, T_MULTU, 32'd1, 32'd2);
    #1;
    chk_eq("not_rtype_stall", 64'(Stall), 64'd0);
    tick();

    // back-to-back MULTU then DIVU
    run_op(T_MULTU, 32'd6, 32'd7, 0, s1);
    chk_eq("b2b_mul_hi", 64'(HI), 64'd0);
    chk_eq("b2b_mul_lo", 64'(LO), 64'd42);
    run_op(T_DIVU, 32'd42, 32'd5, 0, s2);
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    #1;
    chk_eq("b2b_mul_stalls", 64'(s1), 64'd33);
    chk_eq("b2b_div_stalls", 64'(s2), 64'd33);
    chk_eq("b2b_div_lo", 64'(LO), 64'd8);
    chk_eq("b2b_div_hi", 64'(HI), 64'd2);

    // signed corners
    run_op(T_MULT, 32'h8000_0000, 32'h8000_0000, 0, s1);
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    #1;
    chk_eq("mult_min_hi", 64'(HI), 64'h4000_0000);
    chk_eq("mult_min_lo", 64'(LO), 64'h0000_0000);
    run_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, s1);
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    #1;
    chk_eq("div_ovf_lo", 64'(LO), 64'h8000_0000);
    chk_eq("div_ovf_hi", 64'(HI), 64'h0000_0000);
    run_op(T_DIV, 32'd7, 32'hFFFF_FFFE, 0, s1);
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    #1;
    chk_eq("div_7_m2_lo", 64'(LO), 64'hFFFF_FFFD);
    chk_eq("div_7_m2_hi", 64'(HI), 64'h0000_0001);

    // reset on RUN cycle 10 abandons MULT 3 x -5
    drive(1'b1, T_MULT, 32'd3, 32'hFFFF_FFFB);
    #1;
    tick();
    repeat (10) tick();
    chk_eq("run10_stall", 64'(Stall), 64'd1);
    Rst = 1'b1;
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    #1;
    chk_eq("midrst_stall_now", 64'(Stall), 64'd0);
    tick();
    Rst = 1'b0;
    #1;
    chk_eq("midrst_stall_next", 64'(Stall), 64'd0);
    chk_eq("midrst_hi", 64'(HI), 64'd0);
    chk_eq("midrst_lo", 64'(LO), 64'd0);
    drive(1'b1, T_MTHI, 32'hA5A5_A5A5, 32'd0);
    #1;
    chk_eq("midrst_mthi_stall", 64'(Stall), 64'd0);
    tick();
    chk_eq("midrst_idle_mthi", 64'(HI), 64'hA5A5_A5A5);
    run_op(T_MULT, 32'd3, 32'hFFFF_FFFB, 0, s1);
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    #1;
    chk_eq("mult_3_m5_stalls", 64'(s1), 64'd33);
    chk_eq("mult_3_m5_hi", 64'(HI), 64'hFFFF_FFFF);
    chk_eq("mult_3_m5_lo", 64'(LO), 64'hFFFF_FFF1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have Clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have Rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have RType_EX, input, 1 bit: R-type instruction valid in EX.
REQ-004 SHALL have Funct_EX, input, 6 bits: function field of the instruction in EX.
REQ-005 SHALL have RD1_EX and RD2_EX, inputs, 32 bits each: rs and rt operand values in EX.
REQ-006 SHALL have Stall, output, 1 bit: freezes PC, IF/ID and ID/EX; bubbles EX/MEM.
REQ-007 SHALL have HiLo_Out, output, 32 bits: MFHI/MFLO result to the EX result mux.
REQ-008 SHALL have HiLo_Sel, output, 1 bit: high when the EX result comes from HiLo_Out.
REQ-009 SHALL have HI and LO, outputs, 32 bits each: architectural registers.

Function
REQ-010 SHALL decode when RType_EX=1: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B; all other codes are no-ops.
REQ-011 SHALL use FSM states IDLE, RUN, FIN.
REQ-012 SHALL start an operation only in IDLE when a MULT/MULTU/DIV/DIVU is decoded: latch operand magnitudes and sign flags, clear the iteration counter, go to RUN.
REQ-013 SHALL drive Stall combinationally high in the IDLE start cycle and in every RUN cycle; Stall SHALL be low in FIN and in IDLE without a start.
REQ-014 SHALL perform exactly 32 RUN iterations using shift-add for multiply and restoring shift-subtract for divide; a 6-bit counter is 0..31, and the edge at count 31 goes to FIN.
REQ-015 SHALL sign-correct in FIN for signed operations: product negated if the signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
REQ-016 SHALL write HI/LO at the edge ending FIN: MULT/MULTU give HI=product[63:32] and LO=product[31:0]; DIV/DIVU give LO=quotient and HI=remainder; the state then returns to IDLE.
REQ-017 SHALL not restart in FIN even though the same instruction is still in EX.
REQ-018 SHALL give a fixed latency of 34 cycles from start to retire: Stall high for 33 cycles, and the instruction leaves EX at the end of FIN.
REQ-019 SHALL, on divide by zero (either form), still take 33 stall cycles and produce LO=0xFFFFFFFF and HI=dividend (raw RD1 value).
REQ-020 SHALL, in IDLE, make MTHI/MTLO write RD1_EX into HI/LO at the next edge.
REQ-021 SHALL make HiLo_Out combinational (HI for MFHI, LO for MFLO, else 0), with HiLo_Sel=1 only for those two.
REQ-022 SHALL make an MFHI/MFLO in the cycle after FIN observe the new HI/LO value.
REQ-023 SHALL ignore Funct_EX changes during RUN, because operands are latched.

Reset
REQ-024 SHALL, on Rst, set state=IDLE, counter=0, HI=0, LO=0 and clear operand/accumulator registers; Stall=0 and HiLo_Out=0 in that cycle.
REQ-025 SHALL, on Rst asserted mid-RUN or in FIN, abandon the operation with no HI/LO update and have the unit idle the next cycle.
REQ-026 SHALL give Rst priority over every start and every MTHI/MTLO write.

Structure
REQ-027 SHALL place the funct constants, state encoding and ITER=32 in a shared package mdu_pkg.
REQ-028 SHALL implement the per-iteration datapath (64-bit accumulator, shift, add/subtract step) in one sub-module mdu_iter; FSM, HI/LO and decode stay in mul_div_unit.

Verification
REQ-029 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Stall high for 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
REQ-030 SHALL cover: DIV -7 (0xFFFFFFF9) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then MFHI next cycle -> HiLo_Out=0xFFFFFFFF, HiLo_Sel=1.
REQ-031 SHALL cover: DIVU 100 / 0 -> 33 stall cycles, LO=0xFFFFFFFF, HI=0x00000064.
REQ-032 SHALL cover: MTHI 0x12345678, then MTLO 0xCAFEBABE, then MFLO -> HI=0x12345678, HiLo_Out=0xCAFEBABE, Stall never high.
REQ-033 SHALL cover: MULT 3 x -5 with Rst asserted on RUN cycle 10 -> next cycle Stall=0, HI=LO=0, state IDLE.
REQ-034 SHALL cover: back-to-back MULTU 6x7 then DIVU 42/5 -> HI=0, LO=42, then LO=8, HI=2; two separate 33-cycle stalls with no restart in FIN.
